// File: rtl/uart_receiver_if.sv
// Parallel-side bundle of the miniUART receiver: received byte, strobes and busy.
// The parity_error signal exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       framing_error;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;

   modport master (output byte_out, output byte_valid, output framing_error,
                   output busy, output parity_error);
   modport slave  (input byte_out, input byte_valid, input framing_error,
                   input busy, input parity_error);
`else
   modport master (output byte_out, output byte_valid, output framing_error,
                   output busy);
   modport slave  (input byte_out, input byte_valid, input framing_error,
                   input busy);
`endif
endinterface

// File: rtl/uart_receiver.sv
// miniUART receive stage: 8N1 (or 8E1/8O1 with UART_RX_PARITY_EN) mid-bit sampling receiver.
// Optional parity checking is compiled in by defining UART_RX_PARITY_EN.
//
// state      | meaning
// IDLE       | line idle, waiting for rx=0
// START      | counting to mid start bit to reject glitches
// DATA       | sampling 8 data bits, LSB first
// PARITY     | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP       | sampling the stop bit, emitting byte or framing error
// BREAK_WAIT | line held low after a bad stop bit, waiting for rx=1
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter int PARITY_ODD   = 0
`endif
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             serial_input,
   uart_receiver_if.master  rx_if
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((CLKS_PER_BIT / 2) - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] START      = 3'd1;
   localparam logic [2:0] DATA       = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY     = 3'd3;
`endif
   localparam logic [2:0] STOP       = 3'd4;
   localparam logic [2:0] BREAK_WAIT = 3'd5;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             byte_q, byte_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                   par_bad_q, par_bad_d;
   logic                   perr_q, perr_d;
`endif
   logic                   rx;

   assign rx = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], serial_input};
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            if (!rx) state_d = START;
         end
         START: begin
            if (clk_cnt_q == HALF_M1) begin
               clk_cnt_d = '0;
               bit_idx_d = 3'd0;
               state_d   = rx ? IDLE : DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               // total ones over data+parity must be even (PARITY_ODD=0) or odd
               par_bad_d = ((^shift_q) ^ rx) != PARITY_ODD[0];
               state_d   = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               if (rx) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_bad_q;
`endif
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK_WAIT;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         BREAK_WAIT: begin
            clk_cnt_d = '0;
            if (rx) state_d = IDLE;
         end
         default: begin
            clk_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '1;
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         byte_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_if.byte_out      = byte_q;
   assign rx_if.byte_valid    = valid_q;
   assign rx_if.framing_error = ferr_q;
   assign rx_if.busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (default 8N1 build, CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_uart_receiver;
   localparam int CPB = 16;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic serial_input = 1'b1;

   uart_receiver_if rx_if ();

   uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .serial_input (serial_input),
      .rx_if        (rx_if)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int both_cnt  = 0;
   int last_valid_cyc = 0;
   logic [7:0] got_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (rx_if.byte_valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         got_q.push_back(rx_if.byte_out);
      end
      if (rx_if.framing_error === 1'b1) ferr_cnt++;
      if (rx_if.byte_valid === 1'b1 && rx_if.framing_error === 1'b1) both_cnt++;
   end

   task automatic send_bit(input logic b);
      serial_input = b;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_bit);
      serial_input = 1'b1;
   endtask

   task automatic pop_byte(output logic [7:0] v);
      if (got_q.size() > 0) v = got_q.pop_front();
      else v = 8'hxx;
   endtask

   task automatic test_reset();
      int busy_seen;
      reset_n = 1'b0;
      serial_input = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++; if (rx_if.byte_out !== 8'h00) $display("FAIL reset_byte_out: got %h expected 00", rx_if.byte_out); else n_pass++;
      n_checks++; if (rx_if.byte_valid !== 1'b0) $display("FAIL reset_byte_valid: got %b expected 0", rx_if.byte_valid); else n_pass++;
      n_checks++; if (rx_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_if.busy); else n_pass++;
      n_checks++; if (rx_if.framing_error !== 1'b0) $display("FAIL reset_framing_error: got %b expected 0", rx_if.framing_error); else n_pass++;
      reset_n = 1'b1;
      busy_seen = 0;
      repeat (100) begin
         @(negedge clock);
         if (rx_if.busy !== 1'b0) busy_seen++;
      end
      n_checks++; if (busy_seen != 0) $display("FAIL idle_after_reset: busy cycles %0d expected 0", busy_seen); else n_pass++;
   endtask

   task automatic test_single();
      int v0, f0, start_cyc, lat;
      logic [7:0] v;
      v0 = valid_cnt; f0 = ferr_cnt;
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1);
      repeat (20) @(negedge clock);
      n_checks++; if (valid_cnt - v0 != 1) $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); else n_pass++;
      pop_byte(v);
      n_checks++; if (v !== 8'hA5) $display("FAIL single_byte: got %h expected a5", v); else n_pass++;
      lat = last_valid_cyc - start_cyc;
      n_checks++; if (lat < 153 || lat > 155) $display("FAIL single_latency: got %0d expected 153..155", lat); else n_pass++;
      n_checks++; if (ferr_cnt - f0 != 0) $display("FAIL single_framing: got %0d expected 0", ferr_cnt - f0); else n_pass++;
      n_checks++; if (rx_if.byte_out !== 8'hA5) $display("FAIL single_byte_held: got %h expected a5", rx_if.byte_out); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int v0;
      logic [7:0] v;
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
      v0 = valid_cnt;
      for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
      repeat (20) @(negedge clock);
      n_checks++; if (valid_cnt - v0 != 3) $display("FAIL b2b_count: got %0d expected 3", valid_cnt - v0); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         pop_byte(v);
         n_checks++; if (v !== exp_b[i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, v, exp_b[i]); else n_pass++;
      end
   endtask

   task automatic test_glitch();
      int v0, f0, busy_hi;
      v0 = valid_cnt; f0 = ferr_cnt; busy_hi = 0;
      serial_input = 1'b0;
      repeat (4) @(negedge clock);
      serial_input = 1'b1;
      repeat (40) begin
         @(negedge clock);
         if (rx_if.busy === 1'b1) busy_hi++;
      end
      n_checks++; if (busy_hi == 0) $display("FAIL glitch_busy_seen: got 0 busy cycles expected >0"); else n_pass++;
      n_checks++; if (rx_if.busy !== 1'b0) $display("FAIL glitch_idle: got busy %b expected 0", rx_if.busy); else n_pass++;
      n_checks++; if (valid_cnt - v0 != 0) $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (ferr_cnt - f0 != 0) $display("FAIL glitch_framing: got %0d expected 0", ferr_cnt - f0); else n_pass++;
   endtask

   task automatic test_framing();
      int v0, f0;
      logic [7:0] v;
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      serial_input = 1'b0;
      repeat (40) @(negedge clock);
      n_checks++; if (rx_if.busy !== 1'b1) $display("FAIL break_busy: got %b expected 1", rx_if.busy); else n_pass++;
      serial_input = 1'b1;
      repeat (10) @(negedge clock);
      n_checks++; if (rx_if.busy !== 1'b0) $display("FAIL break_release: got busy %b expected 0", rx_if.busy); else n_pass++;
      n_checks++; if (ferr_cnt - f0 != 1) $display("FAIL framing_count: got %0d expected 1", ferr_cnt - f0); else n_pass++;
      n_checks++; if (valid_cnt - v0 != 0) $display("FAIL framing_valid: got %0d expected 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (rx_if.byte_out !== 8'h55) $display("FAIL framing_byte_held: got %h expected 55", rx_if.byte_out); else n_pass++;
      send_frame(8'h81, 1'b1);
      repeat (20) @(negedge clock);
      pop_byte(v);
      n_checks++; if (v !== 8'h81) $display("FAIL after_framing_byte: got %h expected 81", v); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      logic [7:0] d;
      logic [7:0] v;
      d = 8'hC3;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      n_checks++; if (rx_if.busy !== 1'b1) $display("FAIL midframe_busy: got %b expected 1", rx_if.busy); else n_pass++;
      v0 = valid_cnt;
      reset_n = 1'b0;
      serial_input = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++; if (rx_if.byte_out !== 8'h00) $display("FAIL midreset_byte_out: got %h expected 00", rx_if.byte_out); else n_pass++;
      n_checks++; if (rx_if.busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", rx_if.busy); else n_pass++;
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      n_checks++; if (valid_cnt - v0 != 0) $display("FAIL midreset_no_strobe: got %0d expected 0", valid_cnt - v0); else n_pass++;
      send_frame(8'h12, 1'b1);
      repeat (20) @(negedge clock);
      pop_byte(v);
      n_checks++; if (v !== 8'h12) $display("FAIL after_reset_byte: got %h expected 12", v); else n_pass++;
      n_checks++; if (rx_if.byte_out !== 8'h12) $display("FAIL after_reset_byte_out: got %h expected 12", rx_if.byte_out); else n_pass++;
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_reset_mid_frame();
      n_checks++; if (both_cnt != 0) $display("FAIL valid_and_framing_same_cycle: got %0d expected 0", both_cnt); else n_pass++;
      n_checks++; if (got_q.size() != 0) $display("FAIL extra_bytes: got %0d expected 0", got_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
